// File: rtl/event_encoder_8to3.sv
// Sequential 8-to-3 priority encoder: captures event pulses into a pending
// set and serialises them as binary indices over a valid/ready handshake,
// highest index first.
module event_encoder_8to3 #(
    parameter int N_IN   = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   pending,
    output logic              overflow
);

    typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [N_IN-1:0]     pending_q, pending_d;
    logic                overflow_q, overflow_d;

    logic [CODE_W-1:0]   sel;
    logic [N_IN-1:0]     sel_mask;
    logic [N_IN-1:0]     clr_mask;
    logic                load;

    // Highest set index of pending; ascending scan so the top bit wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pending_q[i]) sel = CODE_W'(i);
        end
        sel_mask = N_IN'(1) << sel;
    end

    // Next-state, load decision, pending merge and overflow detection.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    load    = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    if (pending_q != '0) load = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) code_d = sel;
        clr_mask   = load ? sel_mask : '0;
        // A new pulse on a bit being cleared this edge re-arms it; only a
        // pulse landing on a bit that stays set is a lost event.
        pending_d  = (pending_q & ~clr_mask) | in;
        overflow_d = overflow_q | (|(in & pending_q & ~clr_mask));
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = (state_q == VALID);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed bench for event_encoder_8to3: stimulus pushes expected codes into
// a scoreboard queue, a negedge monitor pops and compares on each transfer.
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];

    event_encoder_8to3 dut (
        .clk(clk), .rst(rst), .in(in), .out_code(out_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Compare one value, count it, report on mismatch.
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop on every transfer, and check code stability under stall.
    logic       prev_stall = 1'b0;
    logic [2:0] prev_code  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && out_valid)
                check("stable_code", {5'b0, out_code}, {5'b0, prev_code});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", {5'b0, out_code}, 8'hEE);
                end else begin
                    check("xfer_code", {5'b0, out_code}, {5'b0, exp_q.pop_front()});
                end
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_code  = out_code;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_pending", pending, 8'h00);
        check("rst_valid", {7'b0, out_valid}, 8'h00);
        check("rst_code", {5'b0, out_code}, 8'h00);
        check("rst_ovf", {7'b0, overflow}, 8'h00);

        // 1: single event, 2-cycle latency, one valid cycle
        out_ready = 1'b1; in = 8'h04; exp_q.push_back(3'd2);
        step(); in = '0;
        check("t1_pend", pending, 8'h04);
        check("t1_early_valid", {7'b0, out_valid}, 8'h00);
        step();
        check("t1_valid", {7'b0, out_valid}, 8'h01);
        check("t1_code", {5'b0, out_code}, 8'h02);
        step();
        check("t1_valid_drop", {7'b0, out_valid}, 8'h00);
        check("t1_pend_empty", pending, 8'h00);
        check("t1_ovf", {7'b0, overflow}, 8'h00);

        // 2: priority, back-to-back
        in = 8'h81; exp_q.push_back(3'd7); exp_q.push_back(3'd0);
        step(); in = '0;
        step();
        check("t2_code7", {5'b0, out_code}, 8'h07);
        check("t2_pend", pending, 8'h01);
        step();
        check("t2_valid0", {7'b0, out_valid}, 8'h01);
        check("t2_code0", {5'b0, out_code}, 8'h00);
        step();
        check("t2_drop", {7'b0, out_valid}, 8'h00);

        // 3: backpressure
        out_ready = 1'b0; in = 8'h10; exp_q.push_back(3'd4);
        step(); in = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {7'b0, out_valid}, 8'h01);
            check("t3_hold_code", {5'b0, out_code}, 8'h04);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_after_xfer", {7'b0, out_valid}, 8'h00);

        // 4: overflow, sticky through drain
        in = 8'h08; exp_q.push_back(3'd3);
        step(); in = '0;
        step();
        check("t4_code", {5'b0, out_code}, 8'h03);
        check("t4_pend0", pending, 8'h00);
        step();
        in = 8'h08; step(); in = '0;
        check("t4_pend3", pending, 8'h08);
        check("t4_no_ovf", {7'b0, overflow}, 8'h00);
        step(); step();
        in = 8'h08; step(); in = '0;
        check("t4_ovf", {7'b0, overflow}, 8'h01);
        exp_q.push_back(3'd3);
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        check("t4_drained", {7'b0, out_valid}, 8'h00);
        check("t4_pend_empty", pending, 8'h00);
        check("t4_ovf_sticky", {7'b0, overflow}, 8'h01);
        rst = 1'b1; step(); rst = 1'b0;
        check("t4_ovf_cleared", {7'b0, overflow}, 8'h00);

        // 5: simultaneous clear/set of the same bit
        in = 8'h20; exp_q.push_back(3'd5);
        step(); in = '0;
        step();
        check("t5_code", {5'b0, out_code}, 8'h05);
        in = 8'h20; exp_q.push_back(3'd5);
        step(); in = '0;
        check("t5_pend_rearm", pending, 8'h20);
        out_ready = 1'b1; in = 8'h20; exp_q.push_back(3'd5);
        step(); in = '0;
        check("t5_pend_kept", pending, 8'h20);
        check("t5_valid", {7'b0, out_valid}, 8'h01);
        check("t5_code_again", {5'b0, out_code}, 8'h05);
        check("t5_no_ovf", {7'b0, overflow}, 8'h00);
        step(); step(); step();
        out_ready = 1'b0;
        check("t5_idle", {7'b0, out_valid}, 8'h00);
        check("t5_pend_empty", pending, 8'h00);

        // 6: reset mid-operation discards everything
        in = 8'hFF; exp_q.push_back(3'd7);
        step(); in = '0;
        step();
        check("t6_valid", {7'b0, out_valid}, 8'h01);
        check("t6_code", {5'b0, out_code}, 8'h07);
        check("t6_pend", pending, 8'h7F);
        rst = 1'b1; in = 8'hFF; out_ready = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0; in = '0; out_ready = 1'b0;
        check("t6_pend_rst", pending, 8'h00);
        check("t6_valid_rst", {7'b0, out_valid}, 8'h00);
        check("t6_code_rst", {5'b0, out_code}, 8'h00);
        check("t6_ovf_rst", {7'b0, overflow}, 8'h00);
        step(); step();
        check("t6_stay_idle", {7'b0, out_valid}, 8'h00);
        check("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/event_encoder_8to3.md
Name: event_encoder_8to3

Overview:
- Sequential 8-to-3 priority encoder. It is the encode-side counterpart of the team's 3-to-8 decoder.
- Captures single-cycle event pulses on 8 one-hot request lines into a pending register.
- Emits one 3-bit binary code per event through a valid/ready output handshake, highest index first.
- Used wherever a group of event lines must be serialised into indices for a downstream consumer. That consumer may decode the index back to one-hot.

Parameters:
- N_IN, 8, number of event lines. Fixed at 8 for this block; other values are unsupported.
- CODE_W, 3, output code width. Must equal log2(N_IN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  8  event pulses; bit i high in a cycle = one event on line i.
- out_code  output  3  binary index of the event being presented.
- out_valid  output  1  out_code holds a valid event.
- out_ready  input  1  consumer accepts out_code this cycle.
- pending  output  8  registered set of captured, not-yet-presented events.
- overflow  output  1  sticky flag: an event was lost.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pending=8'h00, out_valid=0, out_code=3'd0, overflow=0, FSM=IDLE.
  - While rst=1, in and out_ready are ignored.
  - Reset mid-operation discards all pending and presented events.
- Handshake: a transfer occurs on a rising edge where out_valid=1 and out_ready=1.
  - out_code and out_valid are registered outputs.
  - out_code must hold stable while out_valid=1 and out_ready=0.
- Selection: sel = highest set index of pending (bit 7 highest priority); sel_mask = one-hot of sel.
- FSM states: IDLE (out_valid=0) and VALID (out_valid=1).
- Load condition: load = (state==IDLE && pending!=0) || (state==VALID && out_ready && pending!=0).
- Transitions:
  - IDLE -> VALID when pending!=0: out_code<=sel, pending bit sel cleared.
  - VALID with out_ready=0: hold.
  - VALID with out_ready=1 and pending!=0: stay in VALID, load next sel in the same edge. Back-to-back transfers, no bubble.
  - VALID with out_ready=1 and pending==0: go to IDLE, out_valid<=0. out_code keeps its last value (don't-care).
- Pending update each edge: pending <= (pending & ~(load ? sel_mask : 0)) | in.
  - If in[i]=1 on the edge where bit i is cleared by a load, bit i remains set. It is a new event, not an overflow.
- Latency: a pulse on in[i] sampled at edge k sets pending[i] at edge k. If no higher-priority work is queued, out_valid rises with out_code=i at edge k+1. Minimum input-to-valid latency is 2 cycles.
- Overflow: at an edge with in[i]=1 where pending[i]=1 and bit i is not being cleared by a load, overflow<=1.
  - overflow is sticky until rst.
  - The duplicate event is merged, i.e. lost.
- Multiple simultaneous in bits are all captured in one edge and presented in descending index order.
- Throughput: at most one code per cycle. Sustained input above 1 event/cycle aggregate eventually sets overflow.
- No combinational path from in or out_ready to any output.

Test Plan:
1. Single event: reset 2 cycles; out_ready=1; in=8'h04 for 1 cycle -> out_valid=1, out_code=2 exactly 2 cycles after the pulse, for 1 cycle; then pending=0, out_valid=0, overflow=0.
2. Priority and back-to-back: out_ready=1; in=8'h81 for 1 cycle -> out_code=7 then out_code=0 on consecutive valid cycles; then out_valid drops.
3. Backpressure: out_ready=0; in=8'h10 pulse -> out_valid=1, out_code=4 held stable for 5 cycles; raise out_ready for 1 cycle -> exactly one transfer; out_valid=0 next cycle.
4. Overflow: out_ready=0; pulse in=8'h08 at cycles 0, 3, 6 -> out_code=3 presented, pending[3]=1 after the second pulse, overflow=1 after the third. overflow stays 1 after draining until rst.
5. Simultaneous clear/set: out_code=5 presented; at the handshake edge with out_ready=1, in=8'h20 -> pending[5]=1, code 5 presented again the next cycle, overflow=0.
6. Reset mid-operation: out_ready=0, in=8'hFF pulse so that out_valid=1 and pending=8'h7F; assert rst 1 cycle with in=8'hFF -> next edge: pending=0, out_valid=0, out_code=0, overflow=0.
